// File: rtl/stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : stage_fetch
//  Description : RV32I instruction fetch stage. Owns the PC, keeps at most
//                two requests outstanding to a variable-latency instruction
//                memory, buffers returned words in a 2-entry FIFO and drives
//                the fetch/decode pipeline register.
//                Optional feature macro: FETCH_MISALIGN_EN (sticky halt on a
//                misaligned redirect target).
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] fetch_instr_addr,
   output logic [31:0] fetch_instr_addr_plus,
   output logic        fetch_valid,
   output logic        fetch_misalign
);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  discard_q, discard_d;
   logic [31:0] resp_addr_q, resp_addr_d;     // address of the next kept response
   logic [1:0]  fifo_count_q, fifo_count_d;
   logic [31:0] fifo_addr_q [2];
   logic [31:0] fifo_addr_d [2];
   logic [31:0] fifo_word_q [2];
   logic [31:0] fifo_word_d [2];
   logic [31:0] instr_q, instr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] addr_plus_q, addr_plus_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;

   logic        halted;
   logic        grant;
   logic        accept;
   logic        bypass;
   logic [2:0]  in_flight;
   logic [31:0] redirect_target;
   logic        misalign_set;

`ifdef FETCH_MISALIGN_EN
   assign redirect_target = redirect_addr;
   assign misalign_set    = redirect && (redirect_addr[1:0] != 2'b00);
`else
   // Targets are word aligned by construction; the low bits are ignored.
   logic unused_redirect_lsbs;
   assign redirect_target      = {redirect_addr[31:2], 2'b00};
   assign misalign_set         = 1'b0;
   assign unused_redirect_lsbs = ^redirect_addr[1:0];
`endif

   assign halted    = misalign_q;
   assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
   assign imem_req  = !rst && !halted && (in_flight < 3'd2);
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;
   // A response is kept only once every pre-redirect response has been dropped.
   assign accept    = imem_rvalid && (discard_q == 2'd0);

   // Next-state computation for PC, counters, FIFO and the output register
   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, imem_rvalid};
      discard_d     = discard_q;
      resp_addr_d   = resp_addr_q;
      misalign_d    = misalign_q | misalign_set;
      fifo_count_d  = fifo_count_q;
      fifo_addr_d   = fifo_addr_q;
      fifo_word_d   = fifo_word_q;
      instr_d       = instr_q;
      addr_d        = addr_q;
      addr_plus_d   = addr_plus_q;
      valid_d       = valid_q;
      bypass        = 1'b0;

      if (redirect) begin
         // Everything still in flight after this edge belongs to the old path.
         pc_d         = redirect_target;
         discard_d    = outstanding_d;
         resp_addr_d  = redirect_target;
         fifo_count_d = 2'd0;
         instr_d      = NOP_INSTR;
         valid_d      = 1'b0;
      end else begin
         if (grant) begin
            pc_d = pc_q + 32'd4;
         end
         if (imem_rvalid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
         end
         if (accept) begin
            resp_addr_d = resp_addr_q + 32'd4;
         end

         if (!stall) begin
            if (fifo_count_q != 2'd0) begin
               instr_d        = fifo_word_q[0];
               addr_d         = fifo_addr_q[0];
               addr_plus_d    = fifo_addr_q[0] + 32'd4;
               valid_d        = 1'b1;
               fifo_addr_d[0] = fifo_addr_q[1];
               fifo_word_d[0] = fifo_word_q[1];
               fifo_count_d   = fifo_count_q - 2'd1;
            end else if (accept) begin
               bypass      = 1'b1;
               instr_d     = imem_rdata;
               addr_d      = resp_addr_q;
               addr_plus_d = resp_addr_q + 32'd4;
               valid_d     = 1'b1;
            end else begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end

         // The issue throttle guarantees a free slot for every kept response.
         if (accept && !bypass) begin
            fifo_addr_d[fifo_count_d[0]] = resp_addr_q;
            fifo_word_d[fifo_count_d[0]] = imem_rdata;
            fifo_count_d                 = fifo_count_d + 2'd1;
         end

         if (halted) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q           <= RESET_PC;
         outstanding_q  <= 2'd0;
         discard_q      <= 2'd0;
         resp_addr_q    <= RESET_PC;
         fifo_count_q   <= 2'd0;
         fifo_addr_q[0] <= 32'd0;
         fifo_addr_q[1] <= 32'd0;
         fifo_word_q[0] <= 32'd0;
         fifo_word_q[1] <= 32'd0;
         instr_q        <= NOP_INSTR;
         addr_q         <= 32'd0;
         addr_plus_q    <= 32'd0;
         valid_q        <= 1'b0;
         misalign_q     <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         outstanding_q  <= outstanding_d;
         discard_q      <= discard_d;
         resp_addr_q    <= resp_addr_d;
         fifo_count_q   <= fifo_count_d;
         fifo_addr_q    <= fifo_addr_d;
         fifo_word_q    <= fifo_word_d;
         instr_q        <= instr_d;
         addr_q         <= addr_d;
         addr_plus_q    <= addr_plus_d;
         valid_q        <= valid_d;
         misalign_q     <= misalign_d;
      end
   end

   assign instr                 = instr_q;
   assign fetch_instr_addr      = addr_q;
   assign fetch_instr_addr_plus = addr_plus_q;
   assign fetch_valid           = valid_q;
   assign fetch_misalign        = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_fetch
//  Description : Self-checking bench for stage_fetch. An in-order memory
//                model with random grant/latency feeds the DUT; the output
//                stream is checked against the expected sequential program
//                order and a fixed address->word function.
//                Honours FETCH_MISALIGN_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, imem_gnt, imem_rvalid;
   logic [31:0] redirect_addr, imem_rdata;
   logic        imem_req, fetch_valid, fetch_misalign;
   logic [31:0] imem_addr, instr, fetch_instr_addr, fetch_instr_addr_plus;

   stage_fetch #(.RESET_PC(RST_PC)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .stall                 (stall),
      .redirect              (redirect),
      .redirect_addr         (redirect_addr),
      .imem_req              (imem_req),
      .imem_addr             (imem_addr),
      .imem_gnt              (imem_gnt),
      .imem_rvalid           (imem_rvalid),
      .imem_rdata            (imem_rdata),
      .instr                 (instr),
      .fetch_instr_addr      (fetch_instr_addr),
      .fetch_instr_addr_plus (fetch_instr_addr_plus),
      .fetch_valid           (fetch_valid),
      .fetch_misalign        (fetch_misalign)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_grant = 0;
   int          n_valid = 0;
   bit          gnt_rand = 0;
   bit          lat_rand = 0;
   int          lat_fix = 0;
   logic [31:0] q_addr [$];
   int          q_rdy [$];
   logic [31:0] exp_next = RST_PC;
   logic        exp_mis = 1'b0;
   logic        got_valid = 1'b0;
   logic [31:0] first_addr = 32'd0;

   // Contents of the instruction memory as a pure function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory at the negedge, check outputs after posedge.
   task automatic tick();
      logic        was_rst, was_redir, ld, h_valid;
      logic [31:0] h_instr, h_addr, h_plus, tgt;
      int          extra;
      @(negedge clk);
      was_rst   = rst;
      was_redir = redirect && !rst;
      ld        = !stall || was_redir;
      h_instr   = instr;
      h_addr    = fetch_instr_addr;
      h_plus    = fetch_instr_addr_plus;
      h_valid   = fetch_valid;
      tgt       = redirect_addr;
`ifndef FETCH_MISALIGN_EN
      tgt[1:0]  = 2'b00;
`endif
      if (rst) begin
         q_addr.delete();
         q_rdy.delete();
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = 32'd0;
      end else begin
         imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (q_addr.size() != 0 && q_rdy[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q_addr.pop_front());
            void'(q_rdy.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end
         if (imem_req && imem_gnt) begin
            extra = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
            q_addr.push_back(imem_addr);
            q_rdy.push_back(cyc + 1 + extra);
            n_grant++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (was_rst) begin
         chk("rst_valid", fetch_valid, 1'b0);
         chk("rst_instr", instr, NOP);
         chk("rst_addr", fetch_instr_addr, 32'd0);
         chk("rst_plus", fetch_instr_addr_plus, 32'd0);
         chk("rst_misalign", fetch_misalign, 1'b0);
         chk("rst_req", imem_req, 1'b0);
         chk("rst_imem_addr", imem_addr, RST_PC);
         exp_next = RST_PC;
         exp_mis  = 1'b0;
      end else begin
         if (was_redir) begin
            chk("redir_valid", fetch_valid, 1'b0);
            chk("redir_instr", instr, NOP);
            chk("redir_pc", imem_addr, tgt);
            exp_next = tgt;
`ifdef FETCH_MISALIGN_EN
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
`endif
         end else if (!ld) begin
            chk("stall_instr", instr, h_instr);
            chk("stall_addr", fetch_instr_addr, h_addr);
            chk("stall_plus", fetch_instr_addr_plus, h_plus);
            chk("stall_valid", fetch_valid, h_valid);
         end else if (fetch_valid) begin
            chk("stream_addr", fetch_instr_addr, exp_next);
            chk("stream_word", instr, mem_word(exp_next));
            chk("stream_plus", fetch_instr_addr_plus, exp_next + 32'd4);
            if (!got_valid) first_addr = fetch_instr_addr;
            got_valid = 1'b1;
            n_valid++;
            exp_next = exp_next + 32'd4;
         end else begin
            chk("bubble_instr", instr, NOP);
            chk("bubble_addr_hold", fetch_instr_addr, h_addr);
         end
         chk("misalign", fetch_misalign, exp_mis);
      end
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (!got_valid && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, got_valid, 1'b1);
   endtask

   initial begin
      int snap;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

      // Reset and first-fetch latency with a zero-wait, 1-cycle memory.
      tick(); tick();
      rst = 1'b0; #1;
      chk("c1_req", imem_req, 1'b1);
      chk("c1_addr", imem_addr, 32'h100);
      tick();
      chk("c2_req", imem_req, 1'b1);
      chk("c2_addr", imem_addr, 32'h104);
      chk("c2_valid", fetch_valid, 1'b0);
      tick();
      chk("c3_addr", imem_addr, 32'h108);
      chk("c3_valid", fetch_valid, 1'b1);
      chk("c3_out", fetch_instr_addr, 32'h100);
      tick();
      chk("c4_out", fetch_instr_addr, 32'h104);

      // Sustained throughput of one instruction per cycle.
      snap = n_valid;
      repeat (10) tick();
      chk("throughput", n_valid - snap, 10);

      // Four-cycle stall in steady state.
      snap = n_grant;
      stall = 1'b1;
      repeat (4) tick();
      stall = 1'b0;
      chk("stall_extra_reqs", (n_grant - snap) <= 2, 1'b1);
      repeat (4) tick();

      // Redirect with two requests outstanding on a slow memory.
      lat_fix = 2;
      repeat (5) tick();
      redirect = 1'b1; redirect_addr = 32'h200;
      tick();
      redirect = 1'b0; lat_fix = 0; got_valid = 1'b0;
      wait_valid(20, "redir2");
      chk("redir2_first", first_addr, 32'h200);
      repeat (3) tick();

      // Redirect and stall together: redirect wins.
      stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h200;
      tick();
      stall = 1'b0; redirect = 1'b0; got_valid = 1'b0;
      chk("rs_req", imem_req, 1'b1);
      wait_valid(20, "redir_stall");
      chk("redir_stall_first", first_addr, 32'h200);

      // Address wrap-around at the top of memory.
      redirect = 1'b1; redirect_addr = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      snap = n_valid;
      repeat (8) tick();
      chk("wrap_count", n_valid - snap >= 5, 1'b1);

`ifndef FETCH_MISALIGN_EN
      // Misaligned target is forced to the word boundary.
      redirect = 1'b1; redirect_addr = 32'h202;
      tick();
      redirect = 1'b0; got_valid = 1'b0;
      wait_valid(20, "misal_off");
      chk("misal_off_first", first_addr, 32'h200);
`endif

      // Random grant/latency, stalls and redirects over 1000 instructions.
      gnt_rand = 1; lat_rand = 1;
      snap = n_valid;
      for (int i = 0; i < 20000 && (n_valid - snap) < 1000; i++) begin
         stall         = ($urandom_range(0, 7) == 0);
         redirect      = ($urandom_range(0, 49) == 0);
         redirect_addr = $urandom;
`ifdef FETCH_MISALIGN_EN
         redirect_addr[1:0] = 2'b00;
`endif
         tick();
      end
      stall = 1'b0; redirect = 1'b0;
      chk("random_progress", (n_valid - snap) >= 1000, 1'b1);

      // Reset in the middle of traffic, then restart from the reset PC.
      rst = 1'b1;
      tick();
      rst = 1'b0; got_valid = 1'b0;
      wait_valid(40, "rst_mid");
      chk("rst_mid_first", first_addr, RST_PC);

`ifdef FETCH_MISALIGN_EN
      // Misaligned redirect halts fetch with a sticky flag.
      gnt_rand = 0; lat_rand = 0;
      redirect = 1'b1; redirect_addr = 32'h202;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("halt_req", imem_req, 1'b0);
         chk("halt_valid", fetch_valid, 1'b0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/stage_fetch.md
# stage_fetch

Instruction fetch stage of the 5-stage RV32I core, directly upstream of the decode stage. It owns the program counter and issues in-order requests to a variable-latency instruction memory, keeping at most two requests outstanding. Returned words go into a 2-entry buffer and then into the fetch/decode pipeline register (`instr`, `fetch_instr_addr`, `fetch_instr_addr_plus`). Execute-stage redirects reload the PC and squash everything in flight; decode-stage stalls hold the pipeline register.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hazard unit holds the fetch/decode register.
- `redirect` in 1: taken branch or jump from execute.
- `redirect_addr` in 32: new PC when `redirect`=1.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request word address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Responses arrive in order, at least 1 cycle after grant.
- `imem_rdata` in 32: response instruction word.
- `instr` out 32: instruction to decode.
- `fetch_instr_addr` out 32: PC of `instr`.
- `fetch_instr_addr_plus` out 32: `fetch_instr_addr` + 4, modulo 2^32.
- `fetch_valid` out 1: `instr` is a real fetched instruction.
- `fetch_misalign` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State:
  - `pc`: next request address.
  - `outstanding`: granted, not yet returned, 0..2.
  - `discard`: responses still to drop, 0..2.
  - 2-entry FIFO of {addr, word}.
  - Output register.
- Request issue:
  - `imem_req` = !rst && !halted && (outstanding + fifo_count) < 2.
  - `imem_addr` = `pc`.
  - On `imem_req && imem_gnt`: `pc` += 4 and `outstanding`++.
  - The address only changes while ungranted on the cycle after a redirect.
- Response handling:
  - On `imem_rvalid`: `outstanding`--.
  - If `discard`>0, decrement `discard` and drop the word.
  - Otherwise push {address of the matching request, `imem_rdata`} into the FIFO.
  - The FIFO tracks the address of each outstanding request in issue order.
- Output register:
  - If `!stall` and the FIFO is non-empty (or a non-discarded response is arriving with the FIFO empty, as a bypass): load the oldest entry and set `fetch_valid`=1.
  - Else if `!stall`: load NOP 32'h0000_0013 and set `fetch_valid`=0. The address outputs hold their previous values.
  - If `stall`: hold all outputs. The FIFO keeps accepting until full; requests throttle via the issue rule.
- Redirect, highest priority over `stall`:
  - `pc` <= `redirect_addr`; FIFO cleared.
  - `discard` <= `outstanding` + (1 if a request is granted this cycle) − (1 if `imem_rvalid` this cycle).
  - Output register <= NOP with `fetch_valid`=0.
- Simultaneous response and grant in one cycle: the counters net to no change.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=32'h0000_0013, `fetch_instr_addr`=0, `fetch_instr_addr_plus`=0, `fetch_valid`=0, `fetch_misalign`=0.
  - All counters 0, FIFO empty.
- The first `imem_req` is asserted in the first cycle with `rst`=0.
- Latency with zero-wait grant and a response 1 cycle after grant: the instruction appears on outputs 2 cycles after its request cycle.
- Sustained throughput is 1 instruction per cycle when responses arrive every cycle.
- After a redirect asserted in cycle N:
  - The new address is requested in N+1.
  - The output is NOP in N+1; first valid is no earlier than N+3.
- `rst` asserted mid-transaction drops all state. The memory must itself drop in-flight responses on `rst`.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_addr[1:0]`≠0 sets `fetch_misalign`=1 on the next edge.
  - `halted`=1: no further requests; the output register loads NOP.
  - Sticky until `rst`.
- Undefined:
  - `redirect_addr[1:0]` is forced to 0.
  - `fetch_misalign` is tied 0 and never halts.

## Test plan
- Reset, `RESET_PC`=0x100, 1-cycle memory, no stalls -> requests 0x100, 0x104, 0x108 on consecutive cycles. Outputs show 0x100/0x104 with the correct words from cycle 3 on, `fetch_valid`=1 and `fetch_instr_addr_plus`=addr+4.
- `stall` held 4 cycles in steady state -> outputs frozen, at most 2 extra requests, no word lost or duplicated after release.
- `redirect` to 0x200 with 2 outstanding -> both late responses dropped; NOP/`fetch_valid`=0 until 0x200's word appears.
- `redirect` and `stall` in the same cycle -> redirect wins: output NOP and `pc`=0x200.
- Random grant/response delays of 0-3 cycles over 1000 instructions -> output address sequence strictly +4 except at redirects, with words matching the memory model.
- Macro on: `redirect_addr`=0x202 -> `fetch_misalign`=1 next cycle and `imem_req` stays 0. Macro off: fetch proceeds from 0x200.
